// File: rtl/instr_pipeline_pkg.sv
// Shared types and constants for the instruction pipeline sequencer.
package instr_pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int DEFAULT_NOP = 0;
  localparam int STAGES_MIN  = 2;
  localparam int STAGES_MAX  = 8;

  function automatic logic stages_ok(input int stages);
    return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
  endfunction

endpackage

// File: rtl/instr_pipeline_stage_reg.sv
// One pipeline stage: valid bit plus instruction register; reads back NOP when empty.
module pipe_stage_reg #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] NOP   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             hold,
  input  logic             clear,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_instr,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_instr
);

  logic             valid_r;
  logic [WIDTH-1:0] instr_r;

  // Stage register: clear beats load, hold blocks load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      instr_r <= NOP;
    end else if (clear) begin
      valid_r <= 1'b0;
      instr_r <= NOP;
    end else if (load && !hold) begin
      valid_r <= d_valid;
      instr_r <= d_valid ? d_instr : NOP;
    end else begin
      valid_r <= valid_r;
      instr_r <= instr_r;
    end
  end

  assign q_valid = valid_r;
  assign q_instr = valid_r ? instr_r : NOP;

endmodule

// File: rtl/instr_pipeline.sv
// Parametrised instruction pipeline sequencer with fetch handshake, hold, flush and sticky halt.
// Optional retire counter enabled by defining INSTR_PIPELINE_RETIRE_COUNT_EN.
module instr_pipeline
  import instr_pipeline_pkg::*;
#(
  parameter int               STAGES    = 2,
  parameter int               WIDTH     = 8,
  parameter int               CNT_WIDTH = 16,
  parameter logic [WIDTH-1:0] NOP       = WIDTH'(DEFAULT_NOP)
) (
  input  logic                    CLK,
  input  logic                    RST_bar,
  input  logic                    IN_VALID,
  input  logic [WIDTH-1:0]        IN_INSTR,
  output logic                    IN_READY,
  input  logic                    HOLD,
  input  logic                    CANCEL,
  input  logic                    HALT_REQ,
  output logic [STAGES*WIDTH-1:0] STAGE_INSTR,
  output logic [STAGES-1:0]       STAGE_VALID,
  output logic                    HALTED,
  output logic [CNT_WIDTH-1:0]    RETIRE_COUNT
);

  if (!stages_ok(STAGES)) begin : g_stages_check
    $error("instr_pipeline: STAGES must be within 2..8");
  end

  state_t state_r;
  state_t state_next_s;

  logic             halt_take_s;
  logic             cancel_take_s;
  logic             advance_s;
  logic             freeze_s;
  logic             accept_s;
  logic             q_valid_s [STAGES];
  logic [WIDTH-1:0] q_instr_s [STAGES];
  logic             d_valid_s [STAGES];
  logic [WIDTH-1:0] d_instr_s [STAGES];

  // Halt is only honoured with a valid instruction in the oldest stage.
  assign halt_take_s   = HALT_REQ && q_valid_s[STAGES-1] && (state_r != ST_HALTED);
  assign cancel_take_s = CANCEL && !halt_take_s && (state_r != ST_HALTED);
  assign advance_s     = !halt_take_s && (state_r != ST_HALTED) && !HOLD && !CANCEL;
  assign freeze_s      = HOLD || halt_take_s || (state_r == ST_HALTED);

  assign IN_READY = RST_bar && (state_r == ST_RUN) && !HOLD && !CANCEL;
  assign accept_s = IN_VALID && IN_READY;
  assign HALTED   = (state_r == ST_HALTED);

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: halt dominates, flush bubble lasts exactly one cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (halt_take_s) begin
          state_next_s = ST_HALTED;
        end else if (CANCEL) begin
          state_next_s = ST_FLUSH;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (halt_take_s) begin
          state_next_s = ST_HALTED;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALTED: begin
        state_next_s = ST_HALTED;
      end
      default: begin
        state_next_s = ST_RUN;
      end
    endcase
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign d_valid_s[i] = accept_s;
      assign d_instr_s[i] = IN_INSTR;
    end else begin : g_body
      assign d_valid_s[i] = q_valid_s[i-1];
      assign d_instr_s[i] = q_instr_s[i-1];
    end

    // Cancel clears every stage: the oldest retires and takes in a bubble.
    pipe_stage_reg #(
      .WIDTH (WIDTH),
      .NOP   (NOP)
    ) u_stage (
      .clk     (CLK),
      .rst_n   (RST_bar),
      .load    (advance_s),
      .hold    (freeze_s),
      .clear   (cancel_take_s),
      .d_valid (d_valid_s[i]),
      .d_instr (d_instr_s[i]),
      .q_valid (q_valid_s[i]),
      .q_instr (q_instr_s[i])
    );

    assign STAGE_INSTR[i*WIDTH +: WIDTH] = q_instr_s[i];
    assign STAGE_VALID[i]                = q_valid_s[i];
  end

`ifdef INSTR_PIPELINE_RETIRE_COUNT_EN
  logic                 retire_take_s;
  logic [CNT_WIDTH-1:0] retire_count_r;

  assign retire_take_s = q_valid_s[STAGES-1] && (advance_s || cancel_take_s);

  // Retire counter, wrapping naturally at its width.
  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      retire_count_r <= {CNT_WIDTH{1'b0}};
    end else if (retire_take_s) begin
      retire_count_r <= retire_count_r + CNT_WIDTH'(1);
    end else begin
      retire_count_r <= retire_count_r;
    end
  end

  assign RETIRE_COUNT = retire_count_r;
`else
  assign RETIRE_COUNT = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: doc/instr_pipeline.md
# instr_pipeline

Parametrised instruction pipeline sequencer that replaces the fixed two-stage pipeline-register pair and its hard-wired CANCEL tie-off. It carries instruction bytes through STAGES registered stages with per-stage valid bits. It adds a fetch handshake, external hold, a real cancel/flush and a sticky halt state. Per-stage control decode (microcode ROMs) stays outside the block and reads STAGE_INSTR.

## Interface
Parameters:
- STAGES, 2, number of pipeline stages (2..8); stage 0 is youngest, stage STAGES-1 is oldest.
- WIDTH, 8, instruction width in bits.
- CNT_WIDTH, 16, retire counter width.
- NOP, 0, instruction value presented by an invalid stage. Matches the dispatch pull-down value.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_bar  in  1  reset, asynchronous and active-low.
- IN_VALID  in  1  fetch offers IN_INSTR this cycle.
- IN_INSTR  in  WIDTH  offered instruction.
- IN_READY  out  1  pipeline accepts IN_INSTR at the next rising edge.
- HOLD  in  1  external stall; freezes all stages.
- CANCEL  in  1  flush all stages except the oldest.
- HALT_REQ  in  1  halt request from the oldest-stage decode.
- STAGE_INSTR  out  STAGES*WIDTH  flattened stage contents; stage i at [i*WIDTH +: WIDTH].
- STAGE_VALID  out  STAGES  per-stage valid.
- HALTED  out  1  pipeline is in the HALTED state.
- RETIRE_COUNT  out  CNT_WIDTH  count of valid instructions leaving the oldest stage.

## Operation
- FSM states:
  - RUN: normal operation.
  - FLUSH: one-cycle fetch redirect bubble.
  - HALTED: sticky until reset.
- Transitions:
  - RUN→FLUSH on CANCEL.
  - FLUSH→RUN unconditionally after one cycle.
  - Any state→HALTED on HALT_REQ when STAGE_VALID[STAGES-1]=1.
  - HALTED exits only on reset.
- IN_READY = (state==RUN) & !HOLD & !CANCEL.
- Advance, taken when state!=HALTED and !HOLD and !CANCEL:
  - stage i+1 ← stage i, for each i.
  - stage 0 ← IN_INSTR with valid=1 if IN_VALID&IN_READY; otherwise a bubble (NOP, valid=0).
- CANCEL:
  - stages 0..STAGES-2 ← NOP/invalid.
  - The oldest stage retires normally; stage STAGES-1 receives the cleared stage STAGES-2, i.e. a bubble.
  - The offered instruction is not accepted.
- HOLD: all stages and the counter are unchanged. IN_READY=0.
- HALTED: all stages freeze. IN_READY=0. CANCEL and HOLD are ignored.
- Invalid stages always drive NOP on STAGE_INSTR.
- Retire: the counter increments by 1 on each advance or cancel edge where STAGE_VALID[STAGES-1]=1. It wraps modulo 2^CNT_WIDTH.
- Priority: reset > HALT_REQ > CANCEL > HOLD > advance.

## Timing
- Reset (RST_bar=0, asynchronous):
  - all STAGE_VALID=0 and all STAGE_INSTR=NOP.
  - state=RUN, HALTED=0, RETIRE_COUNT=0.
  - IN_READY=0 while RST_bar is low.
- IN_READY=1 combinationally from the first cycle after RST_bar rises, absent HOLD/CANCEL.
- Latency: an instruction accepted at edge k is in stage 0 after k and in stage STAGES-1 after edge k+STAGES-1. It retires at edge k+STAGES.
- Throughput: one instruction per cycle with no HOLD.
- CANCEL costs exactly two accept slots: the CANCEL cycle and the FLUSH cycle.
- HALT_REQ is sampled at the edge. The halting instruction stays in the oldest stage, valid, and is not counted as retired.
- Reset mid-operation: all state clears immediately, regardless of FSM state.
- HOLD and CANCEL in the same cycle: CANCEL wins and the flush takes effect.
- HALT_REQ with STAGE_VALID[STAGES-1]=0 is ignored.
- HALTED=1 from the edge that samples a qualifying HALT_REQ.

## Configuration
- INSTR_PIPELINE_RETIRE_COUNT_EN:
  - Defined: the retire counter is implemented as above.
  - Undefined: no counter flops; RETIRE_COUNT is tied to 0. All other behaviour is identical.

## Structure
- Package instr_pipeline_pkg:
  - FSM state enum: ST_RUN, ST_FLUSH, ST_HALTED.
  - Default NOP constant.
  - STAGES bounds check constants.
- Sub-module pipe_stage_reg: one stage (valid + WIDTH-bit register), with load, hold and clear inputs and asynchronous active-low reset.
  - Instantiated STAGES times in a generate loop.
  - Its output mux drives NOP when invalid.

## Test plan
- Reset then stream: IN_VALID=1 with instructions 0x11, 0x22, 0x33 on consecutive cycles, STAGES=2.
  - 0x11 appears in stage 1 two edges after acceptance.
  - RETIRE_COUNT reaches 3 after the last retires.
- Bubble: IN_VALID=0 for one cycle between 0x44 and 0x55.
  - STAGE_VALID shows 0 in the matching stage.
  - STAGE_INSTR for that stage =0x00.
- HOLD for 3 cycles with stages full (0xA1, 0xA2).
  - Contents and RETIRE_COUNT unchanged.
  - IN_READY=0 throughout.
  - Advance resumes exactly on HOLD release.
- CANCEL with stages 0xB1 (stage0) and 0xB2 (stage1), HOLD also high.
  - 0xB2 retires (count +1); stage 0 is cleared.
  - FLUSH lasts one cycle, then IN_READY=1.
- HALT_REQ with 0xFF in the oldest stage, CANCEL asserted simultaneously.
  - HALTED=1; stages freeze; count not incremented.
  - Later CANCEL/HOLD have no effect; only RST_bar=0 clears it.
- Wrap and reset mid-flush:
  - CNT_WIDTH=4, 17 retirements → RETIRE_COUNT=1.
  - Asserting RST_bar=0 during FLUSH clears all outputs asynchronously, before the next edge.
